frame_read_sched: RTL and testbench

Sequences the sample ROM (512000 x 16-bit bearing signal) into fixed-length frames for the 1D-conv/FFT datapath. It replaces free-running timer scheduling with a start/ready handshake. It issues ROM addresses for one frame at a time, aligns the ROM read latency, and tags samples with frame start/end markers. Sits between the sample ROM and the first conv stage.

---
 rtl/frame_sched_pkg.sv | 28 ++
 rtl/rd_valid_pipe.sv | 37 +++
 rtl/frame_read_sched.sv | 179 +++++++++++++++++
 tb/tb_frame_read_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared types and defaults for the frame read scheduler
package frame_sched_pkg;

    localparam int DEF_FRAME_LEN  = 2048;
    localparam int DEF_NUM_FRAMES = 250;
    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_DATA_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_READ,
        ST_FLUSH,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } tag_t;

    function automatic int off_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// rtl/rd_valid_pipe.sv - shift pipeline aligning {valid, sof, eof} with ROM read data
module rd_valid_pipe
    import frame_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  tag_t tag_in,
    output logic tap_valid,
    output tag_t tag_out
);

    tag_t [DEPTH-1:0] stage_q;
    tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], tag_in};
        if (clr) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Tap sits one stage short of the output so the data register can be loaded in step.
    assign tap_valid = stage_q[DEPTH-2].valid;
    assign tag_out   = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_read_sched.sv
// rtl/frame_read_sched.sv - walks the sample ROM one frame at a time behind a start/ready handshake
module frame_read_sched
    import frame_sched_pkg::*;
#(
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IDX_W      = 8,
    parameter int GAP_CYCLES = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic              eng_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              frame_sof,
    output logic              frame_eof,
    output logic [IDX_W-1:0]  frame_idx,
    output logic              busy,
    output logic              done
);

    localparam int OFF_W = off_width(FRAME_LEN);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int FL_W  = $clog2(ROM_LAT + 2);

    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_FRAMES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(ROM_LAT);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(FRAME_LEN);

    if (longint'(NUM_FRAMES) * longint'(FRAME_LEN) > (longint'(1) << ADDR_W)) begin : g_addr_chk
        $error("frame_read_sched: NUM_FRAMES*FRAME_LEN exceeds the ROM address space");
    end
    if ((FRAME_LEN & (FRAME_LEN - 1)) != 0 || ROM_LAT < 1 || GAP_CYCLES < 1 ||
        (longint'(1) << IDX_W) < longint'(NUM_FRAMES)) begin : g_param_chk
        $error("frame_read_sched: illegal FRAME_LEN, ROM_LAT, GAP_CYCLES or IDX_W");
    end

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [FL_W-1:0]     fl_q, fl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;

    logic abort_act;
    logic tap_valid;
    tag_t tag_in, tag_out;

    assign abort_act = abort && (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            offset_q <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            fl_q     <= '0;
            addr_q   <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            fl_q     <= fl_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        base_d   = base_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        fl_d     = fl_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_ARM;
                    idx_d   = '0;
                    base_d  = '0;
                end
            end
            ST_ARM: begin
                if (eng_ready) begin
                    state_d  = ST_READ;
                    offset_d = '0;
                end
            end
            ST_READ: begin
                offset_d = offset_q + 1'b1;
                if (offset_q == OFF_LAST) begin
                    state_d  = ST_FLUSH;
                    offset_d = '0;
                    fl_d     = '0;
                end
            end
            ST_FLUSH: begin
                fl_d = fl_q + 1'b1;
                // Leave only once the last sample of the frame has been presented.
                if (fl_q == FL_LAST) begin
                    gap_d = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        base_d  = base_q + BASE_STEP;
                        state_d = ST_GAP;
                    end else if (loop_en) begin
                        idx_d   = '0;
                        base_d  = '0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_ARM;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_act) begin
            state_d  = ST_IDLE;
            offset_d = '0;
            gap_d    = '0;
            fl_d     = '0;
        end
    end

    always_comb begin
        rom_en   = (state_q == ST_READ);
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        rom_addr = rom_en ? (base_q + ADDR_W'(offset_q)) : addr_q;
        addr_d   = rom_addr;
        tag_in.valid = rom_en;
        tag_in.sof   = rom_en && (offset_q == '0);
        tag_in.eof   = rom_en && (offset_q == OFF_LAST);
        sample_d = (tap_valid && !abort_act) ? rom_dout : '0;
    end

    rd_valid_pipe #(
        .DEPTH (ROM_LAT + 1)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .clr       (abort_act),
        .tag_in    (tag_in),
        .tap_valid (tap_valid),
        .tag_out   (tag_out)
    );

    assign sample_out   = sample_q;
    assign sample_valid = tag_out.valid;
    assign frame_sof    = tag_out.sof;
    assign frame_eof    = tag_out.eof;
    assign frame_idx    = idx_q;

endmodule

// File: tb/tb_frame_read_sched.sv
// tb/tb_frame_read_sched.sv - bench for frame_read_sched (ROM_LAT=1 and ROM_LAT=2 instances)
module tb_frame_read_sched;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, start1 = 1'b0, abort = 1'b0, loop_en = 1'b0, eng_ready = 1'b0;

    logic        m_start [2], m_abort [2], m_loop [2], m_eng [2];
    logic        m_en [2], m_sv [2], m_sof [2], m_eof [2], m_busy [2], m_done [2];
    logic [18:0] m_addr [2];
    logic [15:0] m_out [2], m_dout [2];
    logic [7:0]  m_idx [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign m_start[0] = start;
    assign m_start[1] = start1;
    assign m_abort[0] = abort;
    assign m_abort[1] = 1'b0;
    assign m_loop[0]  = loop_en;
    assign m_loop[1]  = 1'b0;
    assign m_eng[0]   = eng_ready;
    assign m_eng[1]   = 1'b1;

    function automatic logic [15:0] rom_f(input logic [18:0] a);
        return {a[7:0] ^ 8'h3c, ~a[7:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g + 1;

        frame_read_sched #(
            .FRAME_LEN (8), .NUM_FRAMES (3), .ADDR_W (19), .DATA_W (16),
            .IDX_W (8), .GAP_CYCLES (4), .ROM_LAT (LAT)
        ) u_dut (
            .clk (clk), .reset (reset), .start (m_start[g]), .abort (m_abort[g]),
            .loop_en (m_loop[g]), .eng_ready (m_eng[g]), .rom_en (m_en[g]),
            .rom_addr (m_addr[g]), .rom_dout (m_dout[g]), .sample_out (m_out[g]),
            .sample_valid (m_sv[g]), .frame_sof (m_sof[g]), .frame_eof (m_eof[g]),
            .frame_idx (m_idx[g]), .busy (m_busy[g]), .done (m_done[g])
        );

        logic [15:0] rs [LAT];
        always @(posedge clk) begin
            if (m_en[g]) rs[0] <= rom_f(m_addr[g]);
            for (int k = 1; k < LAT; k++) rs[k] <= rs[k-1];
        end
        assign m_dout[g] = rs[LAT-1];

        // Reference: every output sample is the ROM word of the address issued LAT+1 cycles earlier.
        logic        en_h [LAT+1];
        logic [18:0] ad_h [LAT+1];
        logic [18:0] exp_v, act_v;
        int errs = 0, vcnt = 0, eofcnt = 0, donecnt = 0;
        always begin
            @(negedge clk);
            #1;
            if (reset) begin
                for (int k = 0; k <= LAT; k++) begin
                    en_h[k] = 1'b0;
                    ad_h[k] = '0;
                end
            end else begin
                exp_v = {en_h[LAT], en_h[LAT] && (ad_h[LAT][2:0] == 3'd0),
                         en_h[LAT] && (ad_h[LAT][2:0] == 3'd7),
                         en_h[LAT] ? rom_f(ad_h[LAT]) : 16'h0};
                act_v = {m_sv[g], m_sof[g], m_eof[g], m_out[g]};
                if (act_v !== exp_v) begin
                    errs++;
                    if (errs <= 5)
                        $display("FAIL stream%0d t=%0t {valid,sof,eof,data} got %h expected %h",
                                 g, $time, act_v, exp_v);
                end
                vcnt    += int'(m_sv[g]);
                eofcnt  += int'(m_eof[g]);
                donecnt += int'(m_done[g]);
                for (int k = LAT; k > 0; k--) begin
                    en_h[k] = en_h[k-1];
                    ad_h[k] = ad_h[k-1];
                end
                en_h[0] = m_en[g];
                ad_h[0] = m_addr[g];
                if (m_abort[g] && m_busy[g]) begin
                    for (int k = 0; k <= LAT; k++) en_h[k] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] outs(input int g);
        return {15'd0, m_busy[g], m_done[g], m_en[g], m_addr[g], m_sv[g], m_sof[g],
                m_eof[g], m_out[g], m_idx[g]};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_en();
        int k = 0;
        while (!m_en[0] && k < 100) begin
            tick(1);
            k++;
        end
        check("wait_rom_en", m_en[0], 1);
    endtask

    task automatic burst(input int base, input int idx, input bit exp_done);
        wait_en();
        check("frame_idx", m_idx[0], idx);
        for (int i = 0; i < 8; i++) begin
            check("rd_addr", {m_en[0], m_addr[0]}, {1'b1, 19'(base + i)});
            tick(1);
        end
        check("burst_end", m_en[0], 0);
        tick(2);
        check("done_pulse", m_done[0], exp_done);
        tick(1);
        check("busy_after", m_busy[0], !exp_done);
    endtask

    typedef struct {
        bit do_start;
        bit loop;
        int base;
        int idx;
        bit done;
    } vec_t;

    vec_t tbl [9];

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            loop_en = tbl[r].loop;
            if (tbl[r].do_start) pulse_start();
            burst(tbl[r].base, tbl[r].idx, tbl[r].done);
        end
    endtask

    initial begin
        int snap_v, snap_e, snap_d;
        bit bad;
        tbl[0] = '{1, 0, 0,  0, 0};
        tbl[1] = '{0, 0, 8,  1, 0};
        tbl[2] = '{0, 0, 16, 2, 1};
        tbl[3] = '{1, 1, 0,  0, 0};
        tbl[4] = '{0, 1, 8,  1, 0};
        tbl[5] = '{0, 1, 16, 2, 0};
        tbl[6] = '{0, 1, 0,  0, 0};
        tbl[7] = '{0, 1, 8,  1, 0};
        tbl[8] = '{0, 0, 16, 2, 1};

        tick(2);
        check("reset_state0", outs(0), 0);
        check("reset_state1", outs(1), 0);
        reset = 1'b0;
        tick(2);

        // three-frame run on both instances, then a looping run that ends after a second pass
        eng_ready = 1'b1;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        run_rows(0, 2);
        check("run_done_cnt", g_dut[0].donecnt, 1);
        check("run_samples", g_dut[0].vcnt, 24);
        check("run_eofs", g_dut[0].eofcnt, 3);
        tick(20);
        check("lat2_done_cnt", g_dut[1].donecnt, 1);
        check("lat2_samples", g_dut[1].vcnt, 24);
        check("lat2_idle", m_busy[1], 0);
        run_rows(3, 8);
        check("loop_done_cnt", g_dut[0].donecnt, 2);

        // start and abort together while idle
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", m_busy[0], 0);

        // engine not ready: hold in ARM, then a ready drop mid-frame does not cut the frame
        eng_ready = 1'b0;
        pulse_start();
        bad = 1'b0;
        repeat (20) begin
            if (m_en[0] || !m_busy[0]) bad = 1'b1;
            tick(1);
        end
        check("arm_hold", bad, 0);
        eng_ready = 1'b1;
        tick(1);
        check("arm_to_read", {m_en[0], m_addr[0]}, {1'b1, 19'd0});
        snap_v = g_dut[0].vcnt;
        tick(3);
        eng_ready = 1'b0;
        tick(4);
        check("ready_drop_last", {m_en[0], m_addr[0]}, {1'b1, 19'd7});
        tick(1);
        check("ready_drop_end", m_en[0], 0);
        tick(3);
        check("ready_drop_samples", g_dut[0].vcnt - snap_v, 8);
        tick(10);
        check("arm_stall", {m_busy[0], m_en[0], m_idx[0]}, {1'b1, 1'b0, 8'd1});
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_from_arm", m_busy[0], 0);

        // abort at offset 5 of frame 1
        eng_ready = 1'b1;
        pulse_start();
        burst(0, 0, 0);
        wait_en();
        tick(5);
        check("abort_point", m_addr[0], 13);
        snap_e = g_dut[0].eofcnt;
        snap_d = g_dut[0].donecnt;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_outs", {m_busy[0], m_en[0], m_sv[0], m_sof[0], m_eof[0], m_done[0]}, 0);
        tick(5);
        check("abort_no_eof", g_dut[0].eofcnt, snap_e);
        check("abort_no_done", g_dut[0].donecnt, snap_d);
        pulse_start();
        burst(0, 0, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        // start while busy is ignored; asynchronous reset mid-READ
        pulse_start();
        burst(0, 0, 0);
        wait_en();
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_while_busy", {m_idx[0], m_en[0], m_addr[0]}, {8'd1, 1'b1, 19'd11});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", outs(0), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("post_reset_idle", m_busy[0], 0);

        check("stream0_errors", g_dut[0].errs, 0);
        check("stream1_errors", g_dut[1].errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
